seq_divider: RTL and testbench

- Iterative unsigned restoring divider. It is the inverse-direction companion to the team's combinational tree multipliers.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath. Verification can close the loop: p = a*b, then p/b recovers a.

---
 rtl/seq_divider_pkg.sv | 23 ++
 rtl/seq_divider_div_sub_stage.sv | 31 +++
 rtl/seq_divider.sv | 108 ++++++++++
 tb/tb_seq_divider.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// +--------------------------------------------------------------------+
// | seq_divider_pkg                                                    |
// | Shared FSM encoding and counter sizing for the sequential divider. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package seq_divider_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Iteration counter spans 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_sub_stage.sv
// +--------------------------------------------------------------------+
// | div_sub_stage                                                      |
// | One combinational restoring-division step: shift, trial subtract.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module div_sub_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  assign w_shift = {i_rem, i_bit};
  assign w_trial = w_shift - {1'b0, i_div};

  // A non-negative trial is always below the divisor, so it fits WIDTH bits;
  // on restore the shifted value is below the divisor as well.
  assign o_qbit  = ~w_trial[WIDTH];
  assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// +--------------------------------------------------------------------+
// | seq_divider                                                        |
// | Iterative unsigned restoring divider, one quotient bit per clock.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] r_state;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_d;
  // Partial remainder stays below the divisor, so its top bit is never needed.
  logic [WIDTH-1:0]   r_part;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_q_next;

  div_sub_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .i_rem  (r_part),
    .i_div  (r_d),
    .i_bit  (r_q[WIDTH-1]),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  assign w_q_next = {r_q[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_q    <= dividend;
            r_d    <= divisor;
            r_part <= '0;
            r_cnt  <= '0;
            if (divisor != '0) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
              r_quot  <= '1;
              r_rem   <= dividend;
              r_dbz   <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_q    <= w_q_next;
          r_part <= w_rem_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_quot  <= w_q_next;
            r_rem   <= w_rem_next;
            r_dbz   <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +--------------------------------------------------------------------+
// | tb_seq_divider                                                     |
// | Directed and exhaustive checks of seq_divider at WIDTH 4 and 8.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic       start8;
  logic [7:0] dividend8;
  logic [7:0] divisor8;
  logic       busy8;
  logic       done8;
  logic [7:0] quotient8;
  logic [7:0] remainder8;
  logic       div_by_zero8;

  int checks;
  int errors;

  seq_divider #(.WIDTH(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .dividend    (dividend8),
    .divisor     (divisor8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (quotient8),
    .remainder   (remainder8),
    .div_by_zero (div_by_zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one division starting just after a rising edge; returns edges from
  // the accepting edge until done is seen, and how many of those samples were busy.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int nbusy);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    lat   = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL reset_quot got %0d exp 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_rem got %0d exp 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b exp 0", div_by_zero); end
  endtask

  task automatic test_basic;
    int lat, nbusy;
    int ta[4] = '{13, 15, 5, 0};
    int tb[4] = '{3, 1, 7, 9};
    int tq[4] = '{4, 15, 0, 0};
    int tr[4] = '{1, 0, 5, 0};
    for (int i = 0; i < 4; i++) begin
      do_div(4'(ta[i]), 4'(tb[i]), lat, nbusy);
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_lat %0d/%0d got %0d exp 4", ta[i], tb[i], lat); end
      checks++; if (nbusy !== 4) begin errors++; $display("FAIL basic_busy %0d/%0d got %0d exp 4", ta[i], tb[i], nbusy); end
      checks++; if (quotient !== 4'(tq[i])) begin errors++; $display("FAIL basic_quot %0d/%0d got %0d exp %0d", ta[i], tb[i], quotient, tq[i]); end
      checks++; if (remainder !== 4'(tr[i])) begin errors++; $display("FAIL basic_rem %0d/%0d got %0d exp %0d", ta[i], tb[i], remainder, tr[i]); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz %0d/%0d got %0b exp 0", ta[i], tb[i], div_by_zero); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", done); end
      checks++; if (quotient !== 4'(tq[i])) begin errors++; $display("FAIL basic_hold got %0d exp %0d", quotient, tq[i]); end
    end
  endtask

  task automatic test_div_zero;
    int lat, nbusy;
    do_div(4'd9, 4'd0, lat, nbusy);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dz_lat got %0d exp 0", lat); end
    checks++; if (nbusy !== 0) begin errors++; $display("FAIL dz_busy got %0d exp 0", nbusy); end
    checks++; if (quotient !== 4'd15) begin errors++; $display("FAIL dz_quot got %0d exp 15", quotient); end
    checks++; if (remainder !== 4'd9) begin errors++; $display("FAIL dz_rem got %0d exp 9", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b exp 1", div_by_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dz_done_pulse got %0b exp 0", done); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got %0b exp 1", div_by_zero); end
  endtask

  task automatic test_busy_ignore;
    int lat;
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd4;
    @(posedge clk); #1;
    dividend = 4'd6;
    divisor  = 4'd2;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 2) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++; if (lat !== 4) begin errors++; $display("FAIL busy_ign_lat got %0d exp 4", lat); end
    checks++; if (quotient !== 4'd3) begin errors++; $display("FAIL busy_ign_quot got %0d exp 3", quotient); end
    checks++; if (remainder !== 4'd2) begin errors++; $display("FAIL busy_ign_rem got %0d exp 2", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat, nbusy;
    do_div(4'd7, 4'd2, lat, nbusy);
    checks++; if (quotient !== 4'd3 || remainder !== 4'd1) begin errors++; $display("FAIL b2b_first got %0d r %0d exp 3 r 1", quotient, remainder); end
    // Still in the DONE cycle: start is accepted immediately.
    do_div(4'd8, 4'd3, lat, nbusy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_lat got %0d exp 4", lat); end
    checks++; if (quotient !== 4'd2) begin errors++; $display("FAIL b2b_quot got %0d exp 2", quotient); end
    checks++; if (remainder !== 4'd2) begin errors++; $display("FAIL b2b_rem got %0d exp 2", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int lat, nbusy, saw;
    start    = 1'b1;
    dividend = 4'd11;
    divisor  = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
    checks++; if (quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got q %0d r %0d z %0b exp 0", quotient, remainder, div_by_zero);
    end
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) saw++;
      @(posedge clk); #1;
    end
    checks++; if (saw !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", saw); end
    do_div(4'd11, 4'd2, lat, nbusy);
    checks++; if (quotient !== 4'd5 || remainder !== 4'd1) begin errors++; $display("FAIL abort_fresh got %0d r %0d exp 5 r 1", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive;
    int lat, nbusy;
    logic [3:0] eq, er;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(4'(a), 4'(b), lat, nbusy);
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        checks++; if (lat !== ((b == 0) ? 0 : 4)) begin errors++; $display("FAIL exh_lat %0d/%0d got %0d", a, b, lat); end
        checks++; if (quotient !== eq) begin errors++; $display("FAIL exh_quot %0d/%0d got %0d exp %0d", a, b, quotient, eq); end
        checks++; if (remainder !== er) begin errors++; $display("FAIL exh_rem %0d/%0d got %0d exp %0d", a, b, remainder, er); end
        checks++; if (div_by_zero !== (b == 0)) begin errors++; $display("FAIL exh_dbz %0d/%0d got %0b exp %0b", a, b, div_by_zero, (b == 0)); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_random_w8;
    int lat;
    logic [7:0] a, b, eq, er;
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      start8    = 1'b1;
      dividend8 = a;
      divisor8  = b;
      @(posedge clk); #1;
      start8    = 1'b0;
      dividend8 = 8'($urandom);
      divisor8  = 8'($urandom);
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      eq = (b == 0) ? 8'hFF : a / b;
      er = (b == 0) ? a : a % b;
      checks++; if (lat !== ((b == 0) ? 0 : 8)) begin errors++; $display("FAIL w8_lat %0d/%0d got %0d", a, b, lat); end
      checks++; if (quotient8 !== eq) begin errors++; $display("FAIL w8_quot %0d/%0d got %0d exp %0d", a, b, quotient8, eq); end
      checks++; if (remainder8 !== er) begin errors++; $display("FAIL w8_rem %0d/%0d got %0d exp %0d", a, b, remainder8, er); end
      checks++; if (div_by_zero8 !== (b == 0)) begin errors++; $display("FAIL w8_dbz %0d/%0d got %0b", a, b, div_by_zero8); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    start8    = 1'b0;
    dividend8 = '0;
    divisor8  = '0;
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_div_zero;
    test_busy_ignore;
    test_back_to_back;
    test_reset_abort;
    test_exhaustive;
    test_random_w8;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
